// File: rtl/dms_vco_pkg.sv
// ============================================================================
// Module   : dms_vco_pkg
// Purpose  : Shared defaults, clamp encoding and address-width helper for the
//            VCO gain interpolator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dms_vco_pkg;

    localparam int c_VCTRL_W_DEF    = 12;   // control code width, LSB = 0.625 mV
    localparam int c_STEP_SHIFT_DEF = 4;    // 16 codes per 10 mV grid step
    localparam int c_VMIN_CODE_DEF  = 640;  // code of entry 0 (0.4 V)
    localparam int c_N_ENTRIES_DEF  = 161;  // 0.4 V .. 2.0 V in 10 mV steps
    localparam int c_GAIN_W_DEF     = 24;   // unsigned gain word

    // Which end of the table, if any, a code was clamped to.
    typedef enum logic [1:0] {
        CLAMP_NONE = 2'd0,
        CLAMP_LO   = 2'd1,
        CLAMP_HI   = 2'd2
    } clamp_e;

    // Address width for a table of n entries (at least one bit).
    function automatic int lut_addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : dms_vco_pkg

`default_nettype wire

// File: rtl/dms_vco_gain_interp_if.sv
// ============================================================================
// Module   : dms_vco_gain_interp_if
// Purpose  : Table-load port plus input/output valid-ready streams of the VCO
//            gain interpolator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dms_vco_gain_interp_if #(
    parameter int VCTRL_W = dms_vco_pkg::c_VCTRL_W_DEF,
    parameter int GAIN_W  = dms_vco_pkg::c_GAIN_W_DEF,
    parameter int ADDR_W  = dms_vco_pkg::lut_addr_w(dms_vco_pkg::c_N_ENTRIES_DEF)
) ();

    // Table load
    logic                lut_we;
    logic [ADDR_W-1:0]   lut_waddr;
    logic [GAIN_W-1:0]   lut_wdata;
    logic                lut_loaded;

    // Control-code stream
    logic                in_valid;
    logic                in_ready;
    logic [VCTRL_W-1:0]  in_vctrl;

    // Gain stream
    logic                out_valid;
    logic                out_ready;
    logic [GAIN_W-1:0]   out_gain;
    logic                out_clamp_lo;
    logic                out_clamp_hi;

    // Side that drives codes and table writes, and consumes gains.
    modport master (
        output lut_we, lut_waddr, lut_wdata,
        input  lut_loaded,
        output in_valid, in_vctrl,
        input  in_ready,
        input  out_valid, out_gain, out_clamp_lo, out_clamp_hi,
        output out_ready
    );

    // The interpolator itself.
    modport slave (
        input  lut_we, lut_waddr, lut_wdata,
        output lut_loaded,
        input  in_valid, in_vctrl,
        output in_ready,
        output out_valid, out_gain, out_clamp_lo, out_clamp_hi,
        input  out_ready
    );

endinterface : dms_vco_gain_interp_if

`default_nettype wire

// File: rtl/dms_vco_gain_lut.sv
// ============================================================================
// Module   : dms_vco_gain_lut
// Purpose  : Gain table with one write port and two registered read ports
//            sharing one read enable. Read-first: a same-cycle write to the
//            address being read returns the old word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dms_vco_gain_lut
    import dms_vco_pkg::*;
#(
    parameter int N_ENTRIES = c_N_ENTRIES_DEF,
    parameter int GAIN_W    = c_GAIN_W_DEF,
    parameter int ADDR_W    = lut_addr_w(N_ENTRIES)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [GAIN_W-1:0] wdata,
    input  wire logic              rd_en,
    input  wire logic [ADDR_W-1:0] raddr_a,
    input  wire logic [ADDR_W-1:0] raddr_b,
    output logic      [GAIN_W-1:0] rdata_a,
    output logic      [GAIN_W-1:0] rdata_b
);

    // Storage is deliberately not reset; the table must be reloaded.
    logic [GAIN_W-1:0] mem_q [N_ENTRIES];

    logic [GAIN_W-1:0] rdata_a_q, rdata_a_d;
    logic [GAIN_W-1:0] rdata_b_q, rdata_b_d;

    // Table write; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < N_ENTRIES)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read data next-state: sample the pre-write contents when enabled.
    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (rd_en) begin
            rdata_a_d = mem_q[raddr_a];
            rdata_b_d = mem_q[raddr_b];
        end
    end

    // Read data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule : dms_vco_gain_lut

`default_nettype wire

// File: rtl/dms_vco_gain_interp.sv
// ============================================================================
// Module   : dms_vco_gain_interp
// Purpose  : Pipelined VCO gain lookup. Maps a control-voltage code onto a
//            runtime-loaded table with linear interpolation between 10 mV
//            grid points, clamping out-of-range codes to the table ends.
//            Pipeline: S0 code capture, S1 index/fraction/clamp, S2 dual
//            table read, S3 interpolated result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dms_vco_gain_interp
    import dms_vco_pkg::*;
#(
    parameter int VCTRL_W    = c_VCTRL_W_DEF,
    parameter int STEP_SHIFT = c_STEP_SHIFT_DEF,
    parameter int VMIN_CODE  = c_VMIN_CODE_DEF,
    parameter int N_ENTRIES  = c_N_ENTRIES_DEF,
    parameter int GAIN_W     = c_GAIN_W_DEF
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dms_vco_gain_interp_if.slave bus
);

    localparam int c_ADDR_W = lut_addr_w(N_ENTRIES);
    localparam int c_OFF_W  = VCTRL_W + 1;
    localparam int c_PROD_W = GAIN_W + STEP_SHIFT + 2;

    localparam logic [c_ADDR_W-1:0]       c_LAST_IDX = c_ADDR_W'(N_ENTRIES - 1);
    localparam logic signed [c_OFF_W-1:0] c_VMIN_S   = c_OFF_W'(VMIN_CODE);
    localparam logic signed [c_OFF_W-1:0] c_TOP_S    = c_OFF_W'((N_ENTRIES - 1) << STEP_SHIFT);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                  s0_valid_q, s0_valid_d;
    logic [VCTRL_W-1:0]    s0_vctrl_q, s0_vctrl_d;

    logic                  s1_valid_q, s1_valid_d;
    logic [c_ADDR_W-1:0]   s1_idx_q,   s1_idx_d;
    logic [STEP_SHIFT-1:0] s1_frac_q,  s1_frac_d;
    clamp_e                s1_clamp_q, s1_clamp_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [STEP_SHIFT-1:0] s2_frac_q,  s2_frac_d;
    clamp_e                s2_clamp_q, s2_clamp_d;

    logic                  out_valid_q,    out_valid_d;
    logic [GAIN_W-1:0]     out_gain_q,     out_gain_d;
    logic                  out_clamp_lo_q, out_clamp_lo_d;
    logic                  out_clamp_hi_q, out_clamp_hi_d;

    logic                  lut_loaded_q,   lut_loaded_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                        w_stall;
    logic                        w_advance;
    logic                        w_in_ready;
    logic                        w_accept;

    logic signed [c_OFF_W-1:0]   w_off;
    logic [c_ADDR_W-1:0]         w_idx;
    logic [STEP_SHIFT-1:0]       w_frac;
    clamp_e                      w_clamp;

    logic [c_ADDR_W-1:0]         w_raddr_b;
    logic [GAIN_W-1:0]           w_g_lo;
    logic [GAIN_W-1:0]           w_g_hi;
    logic signed [GAIN_W:0]      w_diff;
    logic signed [c_PROD_W-1:0]  w_prod;
    logic signed [c_PROD_W-1:0]  w_interp;

    // A held output freezes every stage, including the table read.
    assign w_stall    = out_valid_q & ~bus.out_ready;
    assign w_advance  = ~w_stall;
    assign w_in_ready = lut_loaded_q & ~bus.lut_we & ~w_stall;
    assign w_accept   = bus.in_valid & w_in_ready;

    // Address stage: offset from table origin, then clamp or split into index/fraction.
    always_comb begin
        w_off   = $signed({1'b0, s0_vctrl_q}) - c_VMIN_S;
        w_idx   = c_ADDR_W'(w_off >>> STEP_SHIFT);
        w_frac  = w_off[STEP_SHIFT-1:0];
        w_clamp = CLAMP_NONE;
        if (w_off[c_OFF_W-1]) begin
            // Below the table: entry 0 with zero fraction reproduces g[0].
            w_clamp = CLAMP_LO;
            w_idx   = '0;
            w_frac  = '0;
        end else if (w_off >= c_TOP_S) begin
            // At/above the top grid point: last entry, zero fraction.
            w_clamp = CLAMP_HI;
            w_idx   = c_LAST_IDX;
            w_frac  = '0;
        end
    end

    // Second read address saturates at the last entry; only reached with frac = 0.
    assign w_raddr_b = (s1_idx_q == c_LAST_IDX) ? s1_idx_q : (s1_idx_q + c_ADDR_W'(1));

    dms_vco_gain_lut #(
        .N_ENTRIES (N_ENTRIES),
        .GAIN_W    (GAIN_W),
        .ADDR_W    (c_ADDR_W)
    ) u_lut (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.lut_we),
        .waddr   (bus.lut_waddr),
        .wdata   (bus.lut_wdata),
        .rd_en   (w_advance),
        .raddr_a (s1_idx_q),
        .raddr_b (w_raddr_b),
        .rdata_a (w_g_lo),
        .rdata_b (w_g_hi)
    );

    // Interpolation: g_lo + floor((g_hi - g_lo) * frac / 2^STEP_SHIFT).
    always_comb begin
        w_diff   = $signed({1'b0, w_g_hi}) - $signed({1'b0, w_g_lo});
        w_prod   = c_PROD_W'(w_diff) * $signed(c_PROD_W'({1'b0, s2_frac_q}));
        w_interp = $signed(c_PROD_W'({1'b0, w_g_lo})) + (w_prod >>> STEP_SHIFT);
    end

    // Pipeline next-state: all stages move together, or hold during a stall.
    always_comb begin
        s0_valid_d     = s0_valid_q;
        s0_vctrl_d     = s0_vctrl_q;
        s1_valid_d     = s1_valid_q;
        s1_idx_d       = s1_idx_q;
        s1_frac_d      = s1_frac_q;
        s1_clamp_d     = s1_clamp_q;
        s2_valid_d     = s2_valid_q;
        s2_frac_d      = s2_frac_q;
        s2_clamp_d     = s2_clamp_q;
        out_valid_d    = out_valid_q;
        out_gain_d     = out_gain_q;
        out_clamp_lo_d = out_clamp_lo_q;
        out_clamp_hi_d = out_clamp_hi_q;

        if (w_advance) begin
            s0_valid_d = w_accept;
            if (w_accept) begin
                s0_vctrl_d = bus.in_vctrl;
            end

            s1_valid_d = s0_valid_q;
            if (s0_valid_q) begin
                s1_idx_d   = w_idx;
                s1_frac_d  = w_frac;
                s1_clamp_d = w_clamp;
            end

            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_frac_d  = s1_frac_q;
                s2_clamp_d = s1_clamp_q;
            end

            // Result registers only change on a real result, so a bubble
            // leaves the last gain visible but flagged invalid.
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_gain_d     = GAIN_W'(w_interp);
                out_clamp_lo_d = (s2_clamp_q == CLAMP_LO);
                out_clamp_hi_d = (s2_clamp_q == CLAMP_HI);
            end
        end
    end

    // Table-loaded flag: sticky once the last entry has been written.
    always_comb begin
        lut_loaded_d = lut_loaded_q;
        if (bus.lut_we && (bus.lut_waddr == c_LAST_IDX)) begin
            lut_loaded_d = 1'b1;
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q     <= 1'b0;
            s0_vctrl_q     <= '0;
            s1_valid_q     <= 1'b0;
            s1_idx_q       <= '0;
            s1_frac_q      <= '0;
            s1_clamp_q     <= CLAMP_NONE;
            s2_valid_q     <= 1'b0;
            s2_frac_q      <= '0;
            s2_clamp_q     <= CLAMP_NONE;
            out_valid_q    <= 1'b0;
            out_gain_q     <= '0;
            out_clamp_lo_q <= 1'b0;
            out_clamp_hi_q <= 1'b0;
            lut_loaded_q   <= 1'b0;
        end else begin
            s0_valid_q     <= s0_valid_d;
            s0_vctrl_q     <= s0_vctrl_d;
            s1_valid_q     <= s1_valid_d;
            s1_idx_q       <= s1_idx_d;
            s1_frac_q      <= s1_frac_d;
            s1_clamp_q     <= s1_clamp_d;
            s2_valid_q     <= s2_valid_d;
            s2_frac_q      <= s2_frac_d;
            s2_clamp_q     <= s2_clamp_d;
            out_valid_q    <= out_valid_d;
            out_gain_q     <= out_gain_d;
            out_clamp_lo_q <= out_clamp_lo_d;
            out_clamp_hi_q <= out_clamp_hi_d;
            lut_loaded_q   <= lut_loaded_d;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_gain     = out_gain_q;
    assign bus.out_clamp_lo = out_clamp_lo_q;
    assign bus.out_clamp_hi = out_clamp_hi_q;
    assign bus.lut_loaded   = lut_loaded_q;

endmodule : dms_vco_gain_interp

`default_nettype wire

// File: tb/tb_dms_vco_gain_interp.sv
// ============================================================================
// Module   : tb_dms_vco_gain_interp
// Purpose  : Scoreboard bench for the VCO gain interpolator with a reference
//            table model and randomized codes, tables and backpressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dms_vco_gain_interp;

    localparam int c_VMIN  = 640;
    localparam int c_SHIFT = 4;
    localparam int c_N     = 161;
    localparam int c_TOP   = (c_N - 1) << c_SHIFT;

    typedef struct {
        logic [23:0] gain;
        logic        lo;
        logic        hi;
    } exp_t;

    logic clk;
    logic rst;

    dms_vco_gain_interp_if #(.VCTRL_W(12), .GAIN_W(24), .ADDR_W(8)) bus ();

    dms_vco_gain_interp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint g [c_N];       // reference copy of the table
    exp_t   sb [$];        // expected results in order
    int     n_vec  = 0;
    int     n_miss = 0;
    int     rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: clamp, else interpolate with floor division by the step size.
    function automatic exp_t model(input int code);
        exp_t   e;
        int     off;
        int     idx;
        int     frac;
        longint t;
        longint q;
        off  = code - c_VMIN;
        e.lo = 1'b0;
        e.hi = 1'b0;
        if (off < 0) begin
            e.lo   = 1'b1;
            e.gain = 24'(g[0]);
        end else if (off >= c_TOP) begin
            e.hi   = 1'b1;
            e.gain = 24'(g[c_N-1]);
        end else begin
            idx  = off / 16;
            frac = off % 16;
            t    = (g[idx+1] - g[idx]) * frac;
            q    = t / 16;
            if ((t % 16 != 0) && (t < 0)) q = q - 1;
            e.gain = 24'(g[idx] + q);
        end
        return e;
    endfunction

    // Downstream ready pattern, changed away from both clock edges.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pop on each output handshake; held outputs must not change.
    logic        held = 1'b0;
    logic [25:0] held_vec;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held = 1'b0;
        end else if (bus.out_valid) begin
            if (held) check("hold_stable", 64'({bus.out_gain, bus.out_clamp_lo, bus.out_clamp_hi}), 64'(held_vec));
            if (bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_result: got gain %0d, expected no output", bus.out_gain);
                end else begin
                    e = sb.pop_front();
                    check("result", 64'({bus.out_gain, bus.out_clamp_lo, bus.out_clamp_hi}),
                          64'({e.gain, e.lo, e.hi}));
                end
                held = 1'b0;
            end else begin
                held     = 1'b1;
                held_vec = {bus.out_gain, bus.out_clamp_lo, bus.out_clamp_hi};
            end
        end else begin
            held = 1'b0;
        end
    end

    // All driving tasks start and end just after a rising edge.
    task automatic write_lut(input int addr, input longint data);
        bus.lut_we    = 1'b1;
        bus.lut_waddr = 8'(addr);
        bus.lut_wdata = 24'(data);
        @(negedge clk);
        check("in_ready_during_write", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.lut_we = 1'b0;
        if (addr < c_N) g[addr] = data;
    endtask

    task automatic issue(input int code);
        bit acc = 1'b0;
        int n   = 0;
        bus.in_valid = 1'b1;
        bus.in_vctrl = 12'(code);
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (acc) sb.push_back(model(code));
        else check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n > 0) #1;
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        exp_t ea;
        exp_t eb;
        int   code;
        bus.lut_we    = 1'b0;
        bus.lut_waddr = '0;
        bus.lut_wdata = '0;
        bus.in_valid  = 1'b0;
        bus.in_vctrl  = '0;
        for (int k = 0; k < c_N; k++) g[k] = 0;
        rst = 1'b1;

        // Reset state, observed off-edge while reset is held.
        #23;
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_in_ready",   64'(bus.in_ready),   64'd0);
        check("rst_lut_loaded", 64'(bus.lut_loaded), 64'd0);
        check("rst_out_gain",   64'(bus.out_gain),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Linear table; loaded flag rises right after the last entry.
        for (int k = 0; k < c_N - 1; k++) write_lut(k, 1000 * k);
        check("loaded_before_last", 64'(bus.lut_loaded), 64'd0);
        write_lut(c_N - 1, 1000 * (c_N - 1));
        check("loaded_after_last", 64'(bus.lut_loaded), 64'd1);
        write_lut(200, 24'h123456);  // out of range, ignored

        // Latency of exactly three edges after acceptance.
        issue(648);
        @(posedge clk); #1;
        check("lat_edge1_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_edge2_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_edge3_valid", 64'(bus.out_valid), 64'd1);
        check("lat_edge3_gain",  64'(bus.out_gain),  64'd500);
        drain();

        // Clamps and grid boundaries.
        issue(100);
        issue(3200);
        issue(4095);
        issue(639);
        issue(640);
        issue(3199);
        issue(0);
        drain();

        // Negative slope.
        write_lut(10, 5000);
        write_lut(11, 4000);
        issue(804);
        issue(810);
        issue(815);
        drain();

        // Random table, then streams under random backpressure.
        rdy_mode = 1;
        for (int k = 0; k < c_N; k++) write_lut(k, longint'($urandom_range(0, 24'hFFFFFF)));
        for (int i = 0; i < 20; i++) issue($urandom_range(640, 3200));
        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 4095));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Write hazard: a code whose read coincides with the write sees old data.
        rdy_mode = 0;
        @(posedge clk);
        #1;
        code = c_VMIN + 20 * 16 + 8;
        ea = model(code);
        bus.in_valid = 1'b1;
        bus.in_vctrl = 12'(code);
        @(negedge clk);
        check("hz_ready_a", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        sb.push_back(ea);
        @(negedge clk);
        check("hz_ready_b", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.lut_we    = 1'b1;
        bus.lut_waddr = 8'd20;
        bus.lut_wdata = 24'(g[20] + 123456);
        @(negedge clk);
        check("hz_we_blocks_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        bus.lut_we = 1'b0;
        g[20] = longint'(bus.lut_wdata);
        eb = model(code);
        sb.push_back(eb);
        drain();

        // Reset mid-stream with the output stalled.
        rdy_mode = 2;
        @(posedge clk); #1;
        issue($urandom_range(640, 3200));
        issue($urandom_range(640, 3200));
        issue($urandom_range(640, 3200));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("stalled_valid", 64'(bus.out_valid), 64'd1);
        sb.delete();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid",  64'(bus.out_valid),  64'd0);
        check("midrst_lut_loaded", 64'(bus.lut_loaded), 64'd0);
        check("midrst_in_ready",   64'(bus.in_ready),   64'd0);
        check("midrst_out_gain",   64'(bus.out_gain),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(bus.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule : tb_dms_vco_gain_interp

`default_nettype wire

// File: doc/dms_vco_gain_interp.md
# dms_vco_gain_interp

Pipelined, synthesizable VCO gain lookup for the CDR loop model. It maps a digital control-voltage code to a gain word using a runtime-loadable table, with linear interpolation between the 10 mV grid points. Out-of-range codes clamp to the table ends. It sits between the loop-filter output quantiser and the VCO phase accumulator, replacing the fixed-file, step-wise lookup.

## Interface
- `VCTRL_W`, 12: control code width, unsigned; LSB = 0.625 mV.
- `STEP_SHIFT`, 4: log2 of codes per table step (16 codes = 10 mV).
- `VMIN_CODE`, 640: code of table entry 0 (0.4 V).
- `N_ENTRIES`, 161: table depth (0.4 V .. 2.0 V); must be ≥ 2.
- `GAIN_W`, 24: unsigned gain word width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `lut_we`  in  1: table write strobe.
- `lut_waddr`  in  $clog2(N_ENTRIES): write address; entries are ascending in voltage.
- `lut_wdata`  in  GAIN_W: write data.
- `lut_loaded`  out  1: table has been loaded (see Operation).
- `in_valid`  in  1: control code valid.
- `in_ready`  out  1: block accepts a code.
- `in_vctrl`  in  VCTRL_W: control code.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts the result.
- `out_gain`  out  GAIN_W: interpolated gain.
- `out_clamp_lo`  out  1: input was below VMIN_CODE.
- `out_clamp_hi`  out  1: input was at or above the top grid point.

## Operation
- A write occurs when `lut_we`=1. Writes to addresses ≥ N_ENTRIES are ignored.
- `lut_loaded` sets on the cycle after a write to address N_ENTRIES-1. It clears only on reset.
- `in_ready` = `lut_loaded` & !`lut_we` & !(`out_valid` & !`out_ready`). A code is accepted when `in_valid` & `in_ready`.
- Address computation: `off` = `in_vctrl` − VMIN_CODE, as a signed value VCTRL_W+1 bits wide. `TOP` = (N_ENTRIES−1) << STEP_SHIFT.
  - If `off` < 0: clamp_lo=1, result = entry 0.
  - If `off` ≥ TOP: clamp_hi=1, result = entry N_ENTRIES−1.
  - Otherwise: idx = `off` >> STEP_SHIFT and frac = low STEP_SHIFT bits of `off`.
- Interpolation: diff = g[idx+1] − g[idx], signed GAIN_W+1 bits.
  - gain = g[idx] + ((diff × frac) >>> STEP_SHIFT), using an arithmetic shift that floors toward negative infinity.
  - The result always lies between g[idx] and g[idx+1], so it fits GAIN_W bits without saturation.
- Non-monotonic tables (negative slope) are legal.
- Table storage is read-first: a read in the same cycle as a write to the same address returns the old data. Each in-flight code completes with the table data present at its read cycle.

## Timing
- Three stages:
  - S1 registers idx, frac and the clamp flags.
  - S2 performs a registered dual read of g[idx] and g[idx+1].
  - S3 registers the interpolated result.
- Latency is 3: a code accepted at edge k gives `out_valid`=1 after edge k+3.
- Throughput is one result per cycle when `out_ready`=1.
- Stall: when `out_valid` & !`out_ready`, all stages and memory read enables freeze. Outputs hold stable until accepted. Results are never lost, duplicated or reordered.
- Reset values:
  - `out_valid`, `out_gain`, both clamp flags and `lut_loaded` are 0, so `in_ready`=0.
  - All pipeline valids are cleared.
  - Table contents are not reset; a reload is required after reset.
- A reset asserted mid-stream drops `out_valid` immediately and discards in-flight codes.

## Structure
- Package `dms_vco_pkg`: default parameter constants and the `clamp_e` encoding {NONE, LO, HI}. It also holds a function computing `$clog2(N_ENTRIES)`.
- Sub-module `dms_vco_gain_lut`: N_ENTRIES×GAIN_W storage with one write port and two registered read ports (addresses idx and idx+1) sharing one read enable, read-first.
- The top level holds the address/clamp stage, valid/stall control, the interpolation datapath and the `lut_loaded` flag.

## Test plan
- Reset: assert `rst` asynchronously → `out_valid`=0, `in_ready`=0, `lut_loaded`=0, `out_gain`=0.
- Linear load: write g[k]=1000·k for k=0..160 → `lut_loaded` rises one cycle after the write to address 160. Then `in_vctrl`=648 → `out_gain`=500 three cycles after acceptance, with no clamp flags.
- Clamp:
  - `in_vctrl`=100 → gain 0, `out_clamp_lo`=1.
  - `in_vctrl`=3200 → gain 160000, `out_clamp_hi`=1.
  - `in_vctrl`=4095 → gain 160000, `out_clamp_hi`=1.
- Negative slope: g[10]=5000, g[11]=4000, `in_vctrl`=804 → 4750.
- Backpressure: stream 20 consecutive codes while toggling `out_ready` pseudo-randomly → all 20 results in order, outputs stable while stalled, no loss or duplication.
- Write hazard: assert `lut_we` during a stream → `in_ready`=0 in that cycle. An in-flight code reading the written entry in the same cycle returns the old value. A reset mid-stream clears `out_valid` and `lut_loaded`.
